// File: rtl/x_bus_arb.sv
// ---------------------------------------------------------------------------
// x_bus_arb
//   Shares one memory port between N_REQ masters. Every port uses the same
//   valid/rnw/addr/data/accept handshake. A master holds its request stable
//   until it sees accept, and read data is sampled in the accept cycle.
//
//   Arbitration is round-robin. The grant stays locked for the whole transfer.
//   The arbiter spends one cycle in IDLE to pick a winner. It then stays in
//   BUSY until the memory accepts the request or the granted master drops
//   valid.
//
// Parameters
//   N_REQ      number of requesting masters (2..8)
//   TO_CYCLES  BUSY cycles without accept before the watchdog fires
//
// Optional feature
//   X_BUS_ARB_WDOG_EN  enables the BUSY watchdog and the sticky o_err flag.
//                      When it is undefined, BUSY waits indefinitely and
//                      o_err is tied to 0.
//
// Ports
//   i_clk, i_nrst              clock, asynchronous active-low reset
//   i_req_valid/rnw            per-master request valid / read-not-write
//   i_req_addr/data            per-master address / write data, master k at [32k+31:32k]
//   o_req_accept               one-hot accept to the granted master
//   o_req_data                 read data broadcast, meaningful only with accept
//   o_mem_valid/rnw/addr/data  downstream request
//   i_mem_accept, i_mem_data   downstream accept and read data
//   o_err                      sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module x_bus_arb #(
  parameter int N_REQ     = 2,
  parameter int TO_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ-1:0]     i_req_rnw,
  input  logic [32*N_REQ-1:0]  i_req_addr,
  input  logic [32*N_REQ-1:0]  i_req_data,
  output logic [N_REQ-1:0]     o_req_accept,
  output logic [31:0]          o_req_data,
  output logic                 o_mem_valid,
  output logic                 o_mem_rnw,
  output logic [31:0]          o_mem_addr,
  output logic [31:0]          o_mem_data,
  input  logic                 i_mem_accept,
  input  logic [31:0]          i_mem_data,
  output logic                 o_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   ptr_r;

  logic               busy_s;
  logic               sel_valid_s;
  logic               sel_rnw_s;
  logic [31:0]        sel_addr_s;
  logic [31:0]        sel_data_s;
  logic               timeout_s;
  logic               done_s;
  logic [IDX_W-1:0]   winner_s;

  // Round-robin search: the first requester after the last-served master, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found && valid[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  assign winner_s = rr_pick(i_req_valid, ptr_r);

  // Mux the granted master's request fields.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rnw_s   = 1'b0;
    sel_addr_s  = 32'h0000_0000;
    sel_data_s  = 32'h0000_0000;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_r == IDX_W'(k)) begin
        sel_valid_s = i_req_valid[k];
        sel_rnw_s   = i_req_rnw[k];
        sel_addr_s  = i_req_addr[32*k +: 32];
        sel_data_s  = i_req_data[32*k +: 32];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  assign busy_s = (state_r == BUSY);

`ifdef X_BUS_ARB_WDOG_EN
  localparam int CNT_W = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wdog_cnt_r;
  logic             err_r;

  assign timeout_s = busy_s && (wdog_cnt_r == CNT_W'(TO_CYCLES));

  // Watchdog counter: held at zero in IDLE and counting BUSY cycles that end without accept.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wdog_cnt_r <= '0;
    end else if (!busy_s) begin
      wdog_cnt_r <= '0;
    end else if (!done_s) begin
      wdog_cnt_r <= wdog_cnt_r + 1'b1;
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end

  // Sticky error flag, set by a timeout and cleared only by reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      err_r <= 1'b0;
    end else if (timeout_s && sel_valid_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign o_err = err_r;
`else
  logic unused_to_cycles_s;

  assign unused_to_cycles_s = (TO_CYCLES > 0);
  assign timeout_s          = 1'b0;
  assign o_err              = 1'b0;
`endif

  // A master that drops valid mid-transfer gets neither a timeout nor an accept.
  assign done_s = busy_s && sel_valid_s && (timeout_s || i_mem_accept);

  // Arbitration FSM: grant, rotation pointer and state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r <= IDLE;
      grant_r <= '0;
      ptr_r   <= IDX_W'(N_REQ - 1);
    end else begin
      case (state_r)
        IDLE: begin
          if (|i_req_valid) begin
            grant_r <= winner_s;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (!sel_valid_s) begin
            state_r <= IDLE;
          end else if (done_s) begin
            ptr_r   <= grant_r;
            state_r <= IDLE;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Downstream request and upstream accept/data; every output is 0 outside BUSY.
  always_comb begin
    o_mem_valid  = 1'b0;
    o_mem_rnw    = 1'b0;
    o_mem_addr   = 32'h0000_0000;
    o_mem_data   = 32'h0000_0000;
    o_req_data   = 32'h0000_0000;
    o_req_accept = '0;
    if (busy_s) begin
      o_mem_valid = sel_valid_s && !timeout_s;
      o_mem_rnw   = sel_rnw_s;
      o_mem_addr  = sel_addr_s;
      o_mem_data  = sel_data_s;
      o_req_data  = timeout_s ? 32'hDEAD_BEEF : i_mem_data;
      for (int k = 0; k < N_REQ; k++) begin
        o_req_accept[k] = done_s && (grant_r == IDX_W'(k));
      end
    end else begin
      o_mem_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_x_bus_arb.sv
module tb_x_bus_arb;

  localparam int N  = 3;
  localparam int TO = 4;
`ifdef X_BUS_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_rnw = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]   req_accept;
  logic [31:0]    req_rdata;
  logic           mem_valid, mem_rnw;
  logic [31:0]    mem_addr, mem_wdata;
  logic           mem_accept = 1'b0;
  logic [31:0]    mem_data = 32'h0;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  x_bus_arb #(.N_REQ(N), .TO_CYCLES(TO)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .i_req_rnw(req_rnw),
    .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_accept(req_accept), .o_req_data(req_rdata),
    .o_mem_valid(mem_valid), .o_mem_rnw(mem_rnw),
    .o_mem_addr(mem_addr), .o_mem_data(mem_wdata),
    .i_mem_accept(mem_accept), .i_mem_data(mem_data),
    .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the port (-1 = nobody) and who was served last.
  int m_own  = -1;
  int m_last = N - 1;
  int m_wait = 0;
  bit m_err  = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!nrst) begin
      chk("m_rst_valid", 32'(mem_valid), 32'h0);
      chk("m_rst_accept", 32'(req_accept), 32'h0);
      chk("m_rst_err", 32'(err), 32'h0);
      m_own  = -1;
      m_last = N - 1;
      m_wait = 0;
      m_err  = 1'b0;
    end else begin
      logic [N-1:0] e_acc;
      logic         e_val;
      logic [31:0]  e_rd;
      int           nxt;
      e_acc = '0;
      e_val = 1'b0;
      e_rd  = mem_data;
      nxt   = m_own;
      chk("m_err", 32'(err), 32'(m_err));
      if (m_own < 0) begin
        chk("m_idle_valid", 32'(mem_valid), 32'h0);
        chk("m_idle_accept", 32'(req_accept), 32'h0);
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (nxt < 0 && req_valid[i]) nxt = i;
        end
        m_wait = 0;
      end else begin
        e_val = req_valid[m_own];
        if (!e_val) begin
          nxt = -1;
        end else if (WDOG && m_wait == TO) begin
          e_acc[m_own] = 1'b1;
          e_rd   = 32'hDEAD_BEEF;
          e_val  = 1'b0;
          m_err  = 1'b1;
          m_last = m_own;
          nxt    = -1;
        end else if (mem_accept) begin
          e_acc[m_own] = 1'b1;
          m_last = m_own;
          nxt    = -1;
        end else begin
          m_wait++;
        end
        chk("m_mem_valid", 32'(mem_valid), 32'(e_val));
        chk("m_accept", 32'(req_accept), 32'(e_acc));
        if (e_val) begin
          chk("m_mem_addr", mem_addr, req_addr[32*m_own +: 32]);
          chk("m_mem_data", mem_wdata, req_data[32*m_own +: 32]);
          chk("m_mem_rnw", 32'(mem_rnw), 32'(req_rnw[m_own]));
        end
        if (e_acc != '0) chk("m_rdata", req_rdata, e_rd);
      end
      m_own = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req_valid = '0;
    mem_accept = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  logic [N-1:0] exp2 [8]  = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd2};
  logic [N-1:0] exp3 [12] = '{3'd0, 3'd4, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd4, 3'd0, 3'd1, 3'd0, 3'd2};

  initial begin
    // Reset state
    tick();
    #1;
    chk("reset_valid", 32'(mem_valid), 32'h0);
    chk("reset_accept", 32'(req_accept), 32'h0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    do_reset();

    // Test 1: m0 read, accepted in the first BUSY cycle
    req_valid[0] = 1'b1; req_rnw[0] = 1'b1; req_addr[31:0] = 32'h0000_0100;
    mem_accept = 1'b1; mem_data = 32'h1234_5678;
    settle();
    chk("t1_arb_accept", 32'(req_accept), 32'h0);
    chk("t1_arb_valid", 32'(mem_valid), 32'h0);
    tick(); settle();
    chk("t1_accept", 32'(req_accept), 32'h1);
    chk("t1_rdata", req_rdata, 32'h1234_5678);
    chk("t1_addr", mem_addr, 32'h0000_0100);
    chk("t1_rnw", 32'(mem_rnw), 32'h1);
    tick();
    req_valid = '0;

    // Test 2: m0 and m1 continuously, then all three masters (wrap and fairness)
    do_reset();
    req_addr[31:0] = 32'h0000_1000; req_addr[63:32] = 32'h0000_2000; req_addr[95:64] = 32'h0000_3000;
    req_valid = 3'b011; mem_accept = 1'b1; mem_data = 32'hA5A5_0000;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("t2_order", 32'(req_accept), 32'(exp2[i]));
      tick();
    end
    req_valid = 3'b111;
    for (int i = 0; i < 12; i++) begin
      settle();
      chk("t2_rr3_order", 32'(req_accept), 32'(exp3[i]));
      tick();
    end
    req_valid = '0; mem_accept = 1'b0;

    // Test 3: m1 write, memory accepts in the 4th BUSY cycle
    do_reset();
    req_valid[1] = 1'b1; req_rnw[1] = 1'b0;
    req_addr[63:32] = 32'h0000_0200; req_data[63:32] = 32'hCAFE_F00D;
    settle();
    chk("t3_arb_accept", 32'(req_accept), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_wait_valid", 32'(mem_valid), 32'h1);
      chk("t3_wait_addr", mem_addr, 32'h0000_0200);
      chk("t3_wait_data", mem_wdata, 32'hCAFE_F00D);
      chk("t3_wait_rnw", 32'(mem_rnw), 32'h0);
      chk("t3_wait_accept", 32'(req_accept), 32'h0);
      tick();
    end
    mem_accept = 1'b1;
    settle();
    chk("t3_accept", 32'(req_accept), 32'h2);
    chk("t3_addr4", mem_addr, 32'h0000_0200);
    tick();
    req_valid = '0; mem_accept = 1'b0;

    // Test 4: m1 arrives while m0 holds the grant
    req_valid[0] = 1'b1; req_addr[31:0] = 32'h0000_0300; req_rnw[0] = 1'b1;
    settle();
    tick();
    req_valid[1] = 1'b1; req_addr[63:32] = 32'h0000_0400;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t4_lock_accept", 32'(req_accept), 32'h0);
      chk("t4_lock_addr", mem_addr, 32'h0000_0300);
      tick();
    end
    mem_accept = 1'b1;
    settle();
    chk("t4_m0_accept", 32'(req_accept), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    settle();
    chk("t4_idle_accept", 32'(req_accept), 32'h0);
    tick(); settle();
    chk("t4_m1_accept", 32'(req_accept), 32'h2);
    chk("t4_m1_addr", mem_addr, 32'h0000_0400);
    tick();
    req_valid = '0; mem_accept = 1'b0;

    // Protocol violation: m0 drops valid in BUSY; the pointer must not advance
    do_reset();
    req_valid[0] = 1'b1;
    tick(); settle();
    chk("pv_busy_valid", 32'(mem_valid), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    settle();
    chk("pv_drop_valid", 32'(mem_valid), 32'h0);
    chk("pv_drop_accept", 32'(req_accept), 32'h0);
    tick();
    req_valid = 3'b011;
    settle();
    tick();
    mem_accept = 1'b1;
    settle();
    chk("pv_m0_wins", 32'(req_accept), 32'h1);
    tick();
    req_valid = '0; mem_accept = 1'b0;

    // Test 5: watchdog (or its absence)
    do_reset();
    req_valid[0] = 1'b1;
`ifdef X_BUS_ARB_WDOG_EN
    tick();
    for (int i = 0; i < TO; i++) begin
      settle();
      chk("t5_wait_accept", 32'(req_accept), 32'h0);
      chk("t5_wait_valid", 32'(mem_valid), 32'h1);
      tick();
    end
    settle();
    chk("t5_to_accept", 32'(req_accept), 32'h1);
    chk("t5_to_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("t5_to_valid", 32'(mem_valid), 32'h0);
    chk("t5_to_err_pre", 32'(err), 32'h0);
    tick();
    req_valid = '0;
    settle();
    chk("t5_err_set", 32'(err), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_err_sticky", 32'(err), 32'h1);
`else
    for (int i = 0; i < 20; i++) tick();
    settle();
    chk("t5_no_wdog_accept", 32'(req_accept), 32'h0);
    chk("t5_no_wdog_valid", 32'(mem_valid), 32'h1);
    chk("t5_no_wdog_err", 32'(err), 32'h0);
    tick();
    req_valid = '0;
`endif

    // Test 6: reset in the middle of a BUSY transfer
    do_reset();
    req_valid[1] = 1'b1; mem_accept = 1'b1;
    tick(); settle();
    chk("t6_m1_accept", 32'(req_accept), 32'h2);
    tick();
    req_valid = 3'b101; req_addr[95:64] = 32'h0000_0500; mem_accept = 1'b0;
    tick(); settle();
    chk("t6_busy_addr", mem_addr, 32'h0000_0500);
    nrst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(mem_valid), 32'h0);
    chk("t6_rst_accept", 32'(req_accept), 32'h0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    tick();
    tick();
    nrst = 1'b1;
    mem_accept = 1'b1;
    settle();
    chk("t6_rel_accept", 32'(req_accept), 32'h0);
    tick(); settle();
    chk("t6_m0_first", 32'(req_accept), 32'h1);
    tick();
    req_valid = '0; mem_accept = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
